// File: rtl/config_stream_loader.sv
// Purpose: configuration bus master that assembles 8-byte little-endian frames
//          (addr, data) from a byte stream and drives each onto the tile bus.
// Latency: a frame appears on the bus the cycle after its byte 7 is accepted and
//          is held for WRITE_CYCLES cycles.
// Backpressure: in_ready is high only while loading; it is low in IDLE, WRITE and DONE.
// Ports: clk/reset (async active-low); start pulse; in_valid/in_data/in_ready byte
//        stream; config_addr/config_data/config_write tile bus; busy/done/frame_count status.
module config_stream_loader #(
    parameter int          WRITE_CYCLES = 1,
    parameter logic [31:0] IDLE_ADDR    = 32'hFFFF_FFFF,
    parameter logic [15:0] END_MOD_ID   = 16'hFFFE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_write,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_count
);

    localparam int HW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(WRITE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [2:0]    byte_idx;
    logic [55:0]   frame_buf;   // bytes 0..6; byte 7 is taken straight from in_data
    logic [HW-1:0] hold_cnt;

    logic        xfer;
    logic        last_byte;
    logic        is_term;
    logic        hold_last;
    logic        start_ok;
    logic [31:0] asm_addr;
    logic [31:0] asm_data;

    assign xfer      = (state == S_LOAD) && in_valid;
    assign last_byte = xfer && (byte_idx == 3'd7);
    assign asm_addr  = frame_buf[31:0];
    assign asm_data  = {in_data, frame_buf[55:32]};
    assign is_term   = (asm_addr[31:16] == END_MOD_ID);
    assign hold_last = (state == S_WRITE) && (hold_cnt == HOLD_LAST);
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (last_byte) state_nxt = is_term ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                if (hold_last) state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state, so none of them glitch
    always_comb begin
        in_ready     = (state == S_LOAD);
        busy         = (state == S_LOAD) || (state == S_WRITE);
        config_write = (state == S_WRITE);
        done         = (state == S_DONE);
    end

    // Datapath: byte assembly, bus registers, hold counter, frame counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx    <= 3'd0;
            frame_buf   <= 56'd0;
            hold_cnt    <= '0;
            config_addr <= IDLE_ADDR;
            config_data <= 32'd0;
            frame_count <= 16'd0;
        end else begin
            if (start_ok) begin
                byte_idx    <= 3'd0;
                frame_count <= 16'd0;
            end
            if (xfer) begin
                if (byte_idx != 3'd7) begin
                    frame_buf[{byte_idx, 3'b000} +: 8] <= in_data;
                end
                byte_idx <= byte_idx + 3'd1;   // wraps to 0 after byte 7
                // The terminator never reaches the bus
                if (last_byte && !is_term) begin
                    config_addr <= asm_addr;
                    config_data <= asm_data;
                end
            end
            if (state == S_WRITE) begin
                if (hold_last) begin
                    hold_cnt    <= '0;
                    config_addr <= IDLE_ADDR;  // data deliberately keeps its last value
                    if (frame_count != 16'hFFFF) begin
                        frame_count <= frame_count + 16'd1;
                    end
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
- Master end of the tile configuration bus; the PE tiles are the receivers.
- Accepts a byte-serial bitstream over a valid/ready handshake and assembles each 8-byte frame into a 32-bit address and 32-bit data word.
- Drives each frame onto the shared config_addr/config_data bus for a fixed number of cycles. Tiles decode the address combinationally and capture on clk.
- Sits at the fabric top level between the external bitstream source and all tiles.

Parameters:
- WRITE_CYCLES, 1, cycles each frame is held on the bus (>=1).
- IDLE_ADDR, 32'hFFFF_FFFF, address driven when no write is active. Its mod_id field [31:16] must match no module.
- END_MOD_ID, 16'hFFFE, mod_id value that marks the terminator frame.

Ports:
- clk  input  1  fabric clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle pulse that begins a load session.
- in_valid  input  1  bitstream byte valid.
- in_data  input  8  bitstream byte.
- in_ready  output  1  loader can accept a byte.
- config_addr  output  32  [31:16] mod_id, [15:0] tile_id.
- config_data  output  32  configuration word.
- config_write  output  1  high while a frame is on the bus (debug/monitor only).
- busy  output  1  session in progress.
- done  output  1  terminator frame received.
- frame_count  output  16  frames written this session.

Behaviour:
- Reset values (async assert, sync deassert):
  - state=IDLE, in_ready=0, config_addr=IDLE_ADDR, config_data=0, config_write=0.
  - busy=0, done=0, frame_count=0, byte index=0, hold counter=0.
- Frame format: 8 bytes, little-endian. Bytes 0-3 form the address (byte 0 = addr[7:0]). Bytes 4-7 form the data (byte 4 = data[7:0]).
- Byte transfer occurs on a rising edge with in_valid && in_ready. in_data is ignored otherwise.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 -> LOAD. Same edge: frame_count cleared, done cleared, byte index cleared.
- LOAD:
  - in_ready=1, busy=1.
  - Each transfer stores the byte at the current index and increments the index.
  - Transfer of byte 7:
    - assembled addr[31:16]==END_MOD_ID -> DONE; no bus write; frame_count unchanged.
    - otherwise -> WRITE; the index wraps to 0.
  - in_valid gaps of any length are allowed; the partial frame is retained.
- WRITE:
  - in_ready=0, busy=1, config_write=1.
  - config_addr/config_data = assembled frame for exactly WRITE_CYCLES consecutive cycles. The first cycle is the one after the byte-7 transfer.
  - Hold counter counts 0..WRITE_CYCLES-1. At terminal count -> LOAD.
  - frame_count increments once per frame on WRITE exit and saturates at 16'hFFFF.
  - On exit: config_addr returns to IDLE_ADDR in the same cycle config_write falls; config_data holds its last value.
- DONE:
  - done=1, busy=0, in_ready=0.
  - Holds until start=1, which behaves as in IDLE (-> LOAD, done cleared).
- start in LOAD or WRITE is ignored.
- Back-to-back frames: minimum spacing is 8 transfer cycles + WRITE_CYCLES. in_ready is low throughout WRITE, so no byte is lost or accepted there.
- Reset mid-frame or mid-write: the partial frame is discarded and all outputs immediately return to reset values. No write completes after reset asserts.
- config_addr never glitches: it is registered, and changes only at WRITE entry and exit.

Test Plan:
- Reset, start, stream one frame with addr 0x0006_0003, data 0x0000_0005 -> config_addr=0x00060003, config_data=5, config_write=1 for exactly 1 cycle, 1 cycle after byte 7. frame_count=1, then in_ready=1 again.
- WRITE_CYCLES=3, two frames sent back-to-back with in_valid held high -> each frame held 3 cycles. in_ready=0 for those 3 cycles. frame_count=2. No byte is dropped (second frame's contents are correct).
- Random in_valid gaps (0-5 cycles) across 10 frames -> bus writes match a scoreboard exactly in order. frame_count=10.
- Terminator frame addr 0xFFFE_0000 after 3 frames -> no config_write, done=1, busy=0, frame_count=3. A new start clears done and count.
- reset driven low after byte 5 of a frame, then released -> config_addr=0xFFFFFFFF, state IDLE. A following start plus a full frame writes the correct new frame with no residue from the discarded bytes.
- start pulsed during LOAD and WRITE -> no effect. The byte index and frame_count continue undisturbed.
